// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor: turns one 256-bit L2 line read/write into a 4-beat x 64-bit memory burst
// and answers the L2 with a single-cycle resp_o once the last beat has been accepted.
module l2_cacheline_adaptor #(
   parameter int s_line    = 256,
   parameter int s_burst   = 64,
   parameter int num_beats = s_line / s_burst
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [s_line-1:0]  line_i,
   output logic [s_line-1:0]  line_o,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [s_burst-1:0] burst_i,
   output logic [s_burst-1:0] burst_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);
   localparam int cw = $clog2(num_beats);
   typedef enum logic [2:0] {IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE} state_t;
   state_t state, state_n;
   logic [cw-1:0] cnt;
   logic [s_line-1:0] line_q;
   logic [31:0] addr_q;
   logic in_burst, last;
   assign in_burst  = state == RD_BURST || state == WR_BURST;
   assign last      = resp_i && cnt == cw'(num_beats - 1);
   assign address_o = addr_q;
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:     state_n = write_i ? WR_BURST : read_i ? RD_BURST : IDLE;
         RD_BURST: state_n = last ? RD_DONE : RD_BURST;
         WR_BURST: state_n = last ? WR_DONE : WR_BURST;
         default:  state_n = IDLE;
      endcase
      read_o  = state == RD_BURST;
      write_o = state == WR_BURST;
      resp_o  = state == RD_DONE || state == WR_DONE;
      burst_o = state == WR_BURST ? line_q[cnt*s_burst +: s_burst] : '0;
   end
   // Beat counter is a power-of-two width, so it wraps to 0 on the last beat by itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         addr_q <= '0;
         line_q <= '0;
         line_o <= '0;
      end else begin
         if (state == IDLE && (read_i || write_i)) addr_q <= address_i;
         if (state == IDLE && write_i) line_q <= line_i;
         if (in_burst && resp_i) cnt <= cnt + 1'b1;
         if (state == RD_BURST && resp_i) line_o[cnt*s_burst +: s_burst] <= burst_i;
      end
   end
endmodule

// File: doc/l2_cacheline_adaptor.md
Name: l2_cacheline_adaptor

Overview:
- Responder for the L2 cache's physical-memory port.
- Accepts one 256-bit cacheline read or write per request on the L2 side.
- Converts each request into a 4-beat x 64-bit burst transaction on the main-memory side.
- Returns a single-cycle completion response to the L2.
- Sits between the L2 cache's line-level port (pmem_address, pmem_rdata, line write data) and the burst memory.

Parameters:
- s_line, 256, cacheline width in bits.
- s_burst, 64, burst beat width in bits.
- num_beats, s_line/s_burst (4), beats per line; beat counter is $clog2(num_beats) bits.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- line_i  in  256  write line from L2 (dirty writeback data).
- line_o  out  256  assembled read line to L2 (drives L2 pmem_rdata).
- address_i  in  32  line address from L2; low 5 bits are zero.
- read_i  in  1  L2 line read request; held until resp_o.
- write_i  in  1  L2 line write request; held until resp_o.
- resp_o  out  1  one-cycle completion pulse to L2.
- burst_i  in  64  read beat from memory.
- burst_o  out  64  write beat to memory.
- address_o  out  32  line address to memory.
- read_o  out  1  burst read request to memory.
- write_o  out  1  burst write request to memory.
- resp_i  in  1  memory beat valid/accept strobe, one per beat.

Behaviour:
- Reset values (synchronous, active-high):
  - State IDLE, beat count 0.
  - resp_o, read_o, write_o = 0.
  - line_o, burst_o, address_o = 0.
  - rst asserted in any state, including mid-burst, aborts the transfer: next cycle is IDLE with all strobes low; the partial line_o is cleared to 0.
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - write_i=1 -> latch address_i and line_i, go to WR_BURST.
  - Otherwise read_i=1 -> latch address_i, go to RD_BURST.
  - read_i and write_i both high: write wins (upstream should never do this).
  - Requests seen in any other state are ignored.
- Address: address_o is driven from the latched address throughout the BURST states and is stable for the whole burst.
- RD_BURST:
  - read_o=1.
  - Each cycle with resp_i=1: line_o[64k+63:64k] <= burst_i for beat k, then k increments.
  - Beat 0 is the lowest 64 bits.
  - Cycles with resp_i=0 stall; there is no timeout.
  - On the beat with k=num_beats-1 and resp_i=1 -> RD_DONE; k wraps to 0.
- RD_DONE:
  - read_o=0, resp_o=1 for exactly this one cycle; line_o holds the full line.
  - Next state IDLE.
  - line_o keeps its value until the next read's first beat.
- WR_BURST:
  - write_o=1; burst_o = latched_line[64k+63:64k] combinationally from the beat counter.
  - Each cycle with resp_i=1 advances k.
  - Last beat accepted -> WR_DONE, k wraps to 0.
- WR_DONE: write_o=0, resp_o=1 for one cycle, then IDLE.
- Latency, zero-wait memory (resp_i=1 every cycle):
  - Request seen in IDLE at cycle 0.
  - read_o/write_o high cycles 1-4.
  - resp_o at cycle 5.
  - Earliest next acceptance at cycle 6.
- Stray resp_i:
  - resp_i in IDLE or DONE is ignored.
  - Beat count changes only in BURST states.
- Since the upstream L2 controller drops read_i/write_i the cycle after resp_o, there are no back-to-back re-triggers; one request is in flight at a time.

Test Plan:
- Read, zero wait: read_i=1, address_i=0x0000_1A20; burst_i beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp_i=1 on cycles 1-4 -> address_o=0x0000_1A20 and read_o=1 on cycles 1-4; resp_o=1 only on cycle 5; line_o={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with stalls: write_i=1, line_i=256'h0123...CDEF, resp_i toggled 1,0,0,1,1,0,1 -> burst_o steps through the 64-bit slices from low to high, advancing only on resp_i=1; write_o low and resp_o pulses exactly once, the cycle after the 4th accepted beat.
- Simultaneous read_i=1 and write_i=1 in IDLE -> write_o asserted, read_o stays 0, line_i is written out.
- Reset mid-read after 2 beats -> next cycle read_o=0, resp_o=0, line_o=0; a fresh read afterwards completes normally with beat 0 landing in bits 63:0.
- Stray resp_i=1 in IDLE for 3 cycles, then a read -> beat counter starts at 0; all 4 beats are still required before resp_o.
- Back-to-back: a write completes, then a read is requested the cycle after resp_o -> the read is accepted in IDLE; address_o switches to the new address; no beat from the write leaks into line_o.
